// File: rtl/t5_pkg.sv
// t5_pkg: shared definitions for the t5 data bus.
//   - SEL_* : byte-lane select encodings driven by the initiator on dwb_sel.
//             SEL_B0 is 4'h0, so the responder must map it to lane 0.
//   - ds_state_e : responder FSM states (DS_IDLE, DS_BUSY, DS_ACK).
//   - sel_to_mask : converts a dwb_sel value into a 4-bit lane write mask.
package t5_pkg;

    localparam logic [3:0] SEL_B0 = 4'h0;
    localparam logic [3:0] SEL_B1 = 4'h2;
    localparam logic [3:0] SEL_B2 = 4'h4;
    localparam logic [3:0] SEL_B3 = 4'h8;
    localparam logic [3:0] SEL_H0 = 4'h3;
    localparam logic [3:0] SEL_H2 = 4'hC;
    localparam logic [3:0] SEL_W0 = 4'hF;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_BUSY = 2'd1,
        DS_ACK  = 2'd2
    } ds_state_e;

    // The all-zero select is the initiator's byte-0 encoding, not "no lanes".
    function automatic logic [3:0] sel_to_mask(input logic [3:0] sel);
        return (sel == SEL_B0) ? 4'b0001 : sel;
    endfunction

endpackage

// File: rtl/t5_dram.sv
// t5_dram: 2^AW x 32 single-port RAM with per-byte write enable.
//   sclk     in   clock
//   addr_i   in   word address
//   we_i     in   byte-lane write enable (bit b writes bits [8b+7:8b])
//   re_i     in   read enable; loads rdata_o at the rising edge
//   wdata_i  in   write data
//   rdata_o  out  registered read data (old contents on a same-edge write)
// Contents and the read register are not reset.
import t5_pkg::*;

module t5_dram #(
    parameter int AW = 10
) (
    input  logic          sclk,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    we_i,
    input  logic          re_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge sclk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/t5_dslv.sv
// t5_dslv: target end of the t5 dwb_* data bus.
// Decodes a word-address window, inserts WAIT wait states, then performs a
// lane-masked write or a full-word read on a local RAM and pulses dwb_ack once.
//   sclk, srst   clock; synchronous active-high reset
//   dwb_adr      word address from the initiator
//   dwb_dto      write data from the initiator
//   dwb_sel      byte-lane select (4'h0 = byte lane 0)
//   dwb_wre      1 = write, 0 = read
//   dwb_stb      transfer strobe
//   dwb_dti      read data, nonzero only in the ack cycle of a read
//   dwb_ack      one-cycle acknowledge
//   dbg_state_o  current FSM state (ds_state_e encoding)
// Handshake: a strobe sampled in IDLE with a window hit starts a transfer;
// the initiator holds address/select/direction/data until the ack cycle;
// dropping the strobe while BUSY aborts without touching the RAM; the strobe
// is ignored during the ack cycle and a strobe seen after it is a new transfer.
import t5_pkg::*;

module t5_dslv #(
    parameter int          XLEN = 32,
    parameter int          AW   = 10,
    parameter int unsigned BASE = 0,
    parameter int unsigned WAIT = 0
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic [XLEN-1:2] dwb_adr,
    input  logic [XLEN-1:0] dwb_dto,
    input  logic [3:0]      dwb_sel,
    input  logic            dwb_wre,
    input  logic            dwb_stb,
    output logic [XLEN-1:0] dwb_dti,
    output logic            dwb_ack,
    output logic [1:0]      dbg_state_o
);

    localparam logic [XLEN-AW-3:0] BASE_TAG = (XLEN-AW-2)'(BASE);
    // The load value already accounts for the BUSY cycle that sees zero.
    localparam logic [CNT_W-1:0]   WAIT_LD  = (WAIT == 0) ? '0 : CNT_W'(WAIT - 1);

    ds_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic             hit;
    logic             commit;
    logic [AW-1:0]    word_idx;
    logic [3:0]       lane_mask;
    logic [3:0]       ram_we;
    logic             ram_re;
    logic [31:0]      ram_rdata;

    assign hit       = dwb_stb && (dwb_adr[XLEN-1:AW+2] == BASE_TAG);
    assign word_idx  = dwb_adr[AW+1:2];
    assign lane_mask = sel_to_mask(dwb_sel);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            DS_IDLE: begin
                if (hit) begin
                    if (WAIT == 0) begin
                        state_d = DS_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = DS_BUSY;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            DS_BUSY: begin
                if (!dwb_stb) begin
                    state_d = DS_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DS_ACK;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DS_ACK: begin
                state_d = DS_IDLE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    // rd_q marks the ack cycle of a read, so it gates the RAM read register.
    assign rd_d = commit && !dwb_wre;

    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= DS_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // A reset on the commit edge must suppress the RAM access as well.
    assign ram_we = (commit && dwb_wre && !srst) ? lane_mask : 4'b0000;
    assign ram_re = commit && !dwb_wre && !srst;

    t5_dram #(
        .AW (AW)
    ) u_dram (
        .sclk    (sclk),
        .addr_i  (word_idx),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .wdata_i (dwb_dto[31:0]),
        .rdata_o (ram_rdata)
    );

    assign dwb_ack     = (state_q == DS_ACK);
    assign dwb_dti     = rd_q ? XLEN'(ram_rdata) : '0;
    assign dbg_state_o = state_q;

endmodule
